uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-stream frame parser sitting directly downstream of the UART receiver. Consumes the receiver's done strobe and data byte, hunts for a sync byte, assembles a fixed 6-byte command frame, verifies an XOR checksum and presents the decoded command on a valid/ready output register. It also reports checksum, inter-byte timeout and overrun errors. It is the boundary between raw serial bytes and the register/command logic.

## Interface
- SYNC_BYTE, 8'h55, frame start marker
- TIMEOUT_CYCLES, 50000, max clk cycles between bytes inside a frame (1 ms at 50 MHz)
- ERR_CNT_W, 8, width of saturating error counter

- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  receiver done strobe; level, may stay high for ≥1 cycle per byte
- rx_data  in  8  received byte, stable while rx_valid high
- cmd_valid  out  1  decoded command available
- cmd_ready  in  1  consumer accepts command when high with cmd_valid
- cmd_op  out  8  opcode byte
- cmd_addr  out  8  address byte
- cmd_data  out  16  {DATA_H, DATA_L}
- err_chk  out  1  one-cycle pulse: checksum mismatch
- err_timeout  out  1  one-cycle pulse: inter-byte timeout
- err_overrun  out  1  one-cycle pulse: good frame dropped, output occupied
- err_cnt  out  ERR_CNT_W  total errors, saturating at all-ones

## Operation
- Frame: SYNC, OP, ADDR, DATA_H, DATA_L, CHK; CHK = OP ^ ADDR ^ DATA_H ^ DATA_L.
- Byte event: rising edge of rx_valid (rx_valid high, registered copy low); a multi-cycle high level yields exactly one event.
- FSM states: HUNT → OP → ADDR → DH → DL → CHK → HUNT. Each byte event advances one state and captures rx_data into the field register.
- HUNT: byte == SYNC_BYTE → OP; any other byte discarded silently, no error.
- CHK: byte == computed checksum → frame good; else err_chk, frame discarded. Either way → HUNT.
- Good frame: if cmd_valid low, or cmd_ready high the same cycle, load output registers; else drop frame, pulse err_overrun, output unchanged.
- Timeout: in any state except HUNT, gap counter increments each cycle, clears on byte event; reaching TIMEOUT_CYCLES-1 → HUNT, pulse err_timeout. Byte event and timeout in the same cycle: byte wins.
- err_cnt increments by one per error pulse; the three pulses are mutually exclusive by construction.
- Checksum is accumulated on the fly (XOR register cleared in HUNT), not recomputed at CHK.

## Timing
- Reset values: cmd_valid 0, cmd_op/cmd_addr/cmd_data 0, all err_* 0, err_cnt 0, state HUNT, gap counter 0.
- Byte event detected in cycle N (rx_valid sampled high, delayed copy low); state/field update at end of N.
- CHK byte event in cycle N → cmd_valid and fields valid from cycle N+1; error pulses also in N+1, one cycle wide.
- cmd_valid holds with stable fields until the cycle cmd_valid && cmd_ready; drops next cycle unless a new good frame loads in that same cycle (then stays high with new fields).
- Timeout pulse in the cycle after the counter reaches TIMEOUT_CYCLES-1.
- Reset mid-frame: immediate return to HUNT, partial frame lost, pending command cleared.
- No combinational path from cmd_ready to any output.

## Structure
- Shared package uart_pkg: state enumeration, frame length constant (6), default SYNC_BYTE, default timeout constant.
- One natural sub-module: uart_gap_timer (gap counter with clear/enable, terminal-count pulse), reusable by the transmit side.

## Test plan
- Bytes 55 01 10 AB CD 77, cmd_ready high -> cmd_valid one cycle, op 01, addr 10, data ABCD; no errors.
- Same frame with CHK 76 -> err_chk one pulse, err_cnt 1, no cmd_valid.
- Bytes 00 FF 12 then valid frame; rx_valid held 2 cycles per byte -> exactly one command, no errors.
- 55 01 then idle TIMEOUT_CYCLES+10 cycles -> err_timeout once, HUNT; following valid frame decodes correctly.
- cmd_ready low, two valid frames (op 01 then op 02) -> second dropped, err_overrun, cmd_op stays 01; raise cmd_ready -> consumed, cmd_valid drops.
- Assert rst_n low after 55 01 10 -> all outputs zero; next complete frame decodes normally.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART byte-stream blocks.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Frame layout: SYNC, OP, ADDR, DATA_H, DATA_L, CHK
   localparam int         c_FRAME_LEN      = 6;
   localparam logic [7:0] c_SYNC_BYTE_DEF  = 8'h55;
   localparam int         c_TIMEOUT_DEF    = 50000;
   localparam int         c_ERR_CNT_W_DEF  = 8;

   // Parser state: one state per expected byte of the frame
   typedef enum logic [2:0] {
      ST_HUNT = 3'd0,
      ST_OP   = 3'd1,
      ST_ADDR = 3'd2,
      ST_DH   = 3'd3,
      ST_DL   = 3'd4,
      ST_CHK  = 3'd5
   } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser_if
// Brief    : Receiver-side byte strobe plus decoded command / error bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_frame_parser_if #(
   parameter int ERR_CNT_W = 8
) ();

   logic                 rx_valid;
   logic [7:0]           rx_data;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [7:0]           cmd_op;
   logic [7:0]           cmd_addr;
   logic [15:0]          cmd_data;
   logic                 err_chk;
   logic                 err_timeout;
   logic                 err_overrun;
   logic [ERR_CNT_W-1:0] err_cnt;

   // Parser side: consumes bytes, produces commands and error reports
   modport master (
      input  rx_valid, rx_data, cmd_ready,
      output cmd_valid, cmd_op, cmd_addr, cmd_data,
      output err_chk, err_timeout, err_overrun, err_cnt
   );

   // Environment side: UART receiver plus command consumer
   modport slave (
      output rx_valid, rx_data, cmd_ready,
      input  cmd_valid, cmd_op, cmd_addr, cmd_data,
      input  err_chk, err_timeout, err_overrun, err_cnt
   );

endinterface
`default_nettype wire

// File: rtl/uart_gap_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_gap_timer
// Brief    : Idle-gap counter with clear/enable; flags the terminal cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_gap_timer #(
   parameter int TERMINAL = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int                 c_CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TERMINAL - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Count idle cycles while enabled; clear, disable or terminal count restart at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (clr || !en || (r_cnt == c_LAST))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + c_CNT_W'(1);
   end

   // A clear in the terminal cycle takes priority over expiry
   assign expired = en && !clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Hunts for SYNC, assembles a 6-byte frame, checks XOR checksum
//            and presents the command on a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = c_SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = c_TIMEOUT_DEF,
   parameter int         ERR_CNT_W      = c_ERR_CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_frame_parser_if.master bus
);

   parse_state_t         r_state;
   parse_state_t         w_state_nxt;
   logic                 r_rx_valid_d;
   logic                 w_byte_evt;
   logic                 w_gap_expired;
   logic [7:0]           r_op, r_addr, r_dh, r_dl, r_chk_acc;
   logic                 w_frame_end, w_chk_ok;
   logic                 w_load, w_overrun, w_chk_err, w_tmo_err;
   logic                 r_cmd_valid;
   logic [7:0]           r_cmd_op, r_cmd_addr;
   logic [15:0]          r_cmd_data;
   logic                 r_err_chk, r_err_timeout, r_err_overrun;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // Delayed strobe so a multi-cycle rx_valid level yields a single byte event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rx_valid_d <= 1'b0;
      else        r_rx_valid_d <= bus.rx_valid;
   end

   assign w_byte_evt = bus.rx_valid && !r_rx_valid_d;

   uart_gap_timer #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_byte_evt),
      .en      (r_state != ST_HUNT),
      .expired (w_gap_expired)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_HUNT;
      else        r_state <= w_state_nxt;
   end

   // Next state: each byte advances one field; an idle gap abandons the frame
   always_comb begin
      w_state_nxt = r_state;
      if (w_byte_evt) begin
         case (r_state)
            ST_HUNT: if (bus.rx_data == SYNC_BYTE) w_state_nxt = ST_OP;
            ST_OP:   w_state_nxt = ST_ADDR;
            ST_ADDR: w_state_nxt = ST_DH;
            ST_DH:   w_state_nxt = ST_DL;
            ST_DL:   w_state_nxt = ST_CHK;
            default: w_state_nxt = ST_HUNT;
         endcase
      end else if (w_gap_expired) begin
         w_state_nxt = ST_HUNT;
      end
   end

   // Frame outcome decode; byte event beats a coincident timeout
   always_comb begin
      w_frame_end = w_byte_evt && (r_state == ST_CHK);
      w_chk_ok    = (bus.rx_data == r_chk_acc);
      w_load      = w_frame_end && w_chk_ok && (!r_cmd_valid || bus.cmd_ready);
      w_overrun   = w_frame_end && w_chk_ok && r_cmd_valid && !bus.cmd_ready;
      w_chk_err   = w_frame_end && !w_chk_ok;
      w_tmo_err   = w_gap_expired && !w_byte_evt;
   end

   // Capture each payload byte into its field register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= '0;
         r_addr <= '0;
         r_dh   <= '0;
         r_dl   <= '0;
      end else if (w_byte_evt) begin
         case (r_state)
            ST_OP:   r_op   <= bus.rx_data;
            ST_ADDR: r_addr <= bus.rx_data;
            ST_DH:   r_dh   <= bus.rx_data;
            ST_DL:   r_dl   <= bus.rx_data;
            default: ;
         endcase
      end
   end

   // Running XOR of payload bytes; held at zero while hunting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_chk_acc <= '0;
      else if (r_state == ST_HUNT)
         r_chk_acc <= '0;
      else if (w_byte_evt && (r_state != ST_CHK))
         r_chk_acc <= r_chk_acc ^ bus.rx_data;
   end

   // Output command register: load on good frame, release on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_valid <= 1'b0;
         r_cmd_op    <= '0;
         r_cmd_addr  <= '0;
         r_cmd_data  <= '0;
      end else if (w_load) begin
         r_cmd_valid <= 1'b1;
         r_cmd_op    <= r_op;
         r_cmd_addr  <= r_addr;
         r_cmd_data  <= {r_dh, r_dl};
      end else if (r_cmd_valid && bus.cmd_ready) begin
         r_cmd_valid <= 1'b0;
      end
   end

   // Single-cycle error pulses and saturating total error count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_chk     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_cnt     <= '0;
      end else begin
         r_err_chk     <= w_chk_err;
         r_err_timeout <= w_tmo_err;
         r_err_overrun <= w_overrun;
         if ((w_chk_err || w_tmo_err || w_overrun) && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign bus.cmd_valid   = r_cmd_valid;
   assign bus.cmd_op      = r_cmd_op;
   assign bus.cmd_addr    = r_cmd_addr;
   assign bus.cmd_data    = r_cmd_data;
   assign bus.err_chk     = r_err_chk;
   assign bus.err_timeout = r_err_timeout;
   assign bus.err_overrun = r_err_overrun;
   assign bus.err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Brief    : Randomized bench for uart_frame_parser with a byte-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;
   import uart_pkg::*;

   localparam int T = 100;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_frame_parser_if #(.ERR_CNT_W(8)) bus ();

   uart_frame_parser #(
      .SYNC_BYTE      (8'h55),
      .TIMEOUT_CYCLES (T),
      .ERR_CNT_W      (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   logic [7:0]  m_buf [c_FRAME_LEN];
   int          m_n   = 0;
   int          m_err = 0;
   int          mon_valid = 0, mon_chk = 0, mon_tmo = 0, mon_ovr = 0;

   // Observe outputs mid-cycle, after the drivers have settled
   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         if (bus.cmd_valid) mon_valid++;
         if (bus.cmd_valid && bus.cmd_ready)
            obs_q.push_back({bus.cmd_op, bus.cmd_addr, bus.cmd_data});
         if (bus.err_chk)     mon_chk++;
         if (bus.err_timeout) mon_tmo++;
         if (bus.err_overrun) mon_ovr++;
      end
   end

   // Reference: collect bytes after a SYNC into a 6-byte frame and judge it
   task automatic model_feed(input logic [7:0] b);
      if (m_n == 0 && b != c_SYNC_BYTE_DEF) return;
      m_buf[m_n] = b;
      m_n++;
      if (m_n == c_FRAME_LEN) begin
         m_n = 0;
         if ((m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4]) == m_buf[5])
            exp_q.push_back({m_buf[1], m_buf[2], m_buf[3], m_buf[4]});
         else
            m_err++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      repeat (hold) @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      model_feed(b);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                             input logic [7:0] dh, input logic [7:0] dl,
                             input logic [7:0] chk, input int hold, input int gap);
      send_byte(8'h55, hold, gap);
      send_byte(op,    hold, gap);
      send_byte(addr,  hold, gap);
      send_byte(dh,    hold, gap);
      send_byte(dl,    hold, gap);
      send_byte(chk,   hold, gap);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic test_reset;
      bus.rx_valid  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.cmd_ready = 1'b0;
      rst_n = 1'b0;
      settle(3);
      @(negedge clk);
      rst_n = 1'b1;
      settle(2);
      n_checks++; if (bus.cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b expected 0", bus.cmd_valid); else n_pass++;
      n_checks++; if ({bus.cmd_op, bus.cmd_addr, bus.cmd_data} !== 32'h0) $display("FAIL reset_fields: got %h expected 0", {bus.cmd_op, bus.cmd_addr, bus.cmd_data}); else n_pass++;
      n_checks++; if ({bus.err_chk, bus.err_timeout, bus.err_overrun} !== 3'b000) $display("FAIL reset_err_pulses: got %b expected 000", {bus.err_chk, bus.err_timeout, bus.err_overrun}); else n_pass++;
      n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d expected 0", bus.err_cnt); else n_pass++;
   endtask

   task automatic test_basic;
      int v0, e0;
      logic [31:0] e, o;
      v0 = mon_valid; e0 = mon_chk + mon_tmo + mon_ovr;
      bus.cmd_ready = 1'b1;
      send_frame(8'h01, 8'h10, 8'hAB, 8'hCD, 8'h77, 1, 1);
      settle(4);
      n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_cmd_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++; if (o !== e) $display("FAIL basic_cmd: got %h expected %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
      n_checks++; if (mon_valid - v0 != 1) $display("FAIL basic_valid_cycles: got %0d expected 1", mon_valid - v0); else n_pass++;
      n_checks++; if (mon_chk + mon_tmo + mon_ovr - e0 != 0) $display("FAIL basic_errors: got %0d expected 0", mon_chk + mon_tmo + mon_ovr - e0); else n_pass++;
   endtask

   task automatic test_chk_error;
      int v0, c0;
      v0 = mon_valid; c0 = mon_chk;
      send_frame(8'h01, 8'h10, 8'hAB, 8'hCD, 8'h76, 1, 1);
      settle(4);
      n_checks++; if (mon_chk - c0 != 1) $display("FAIL chk_err_pulses: got %0d expected 1", mon_chk - c0); else n_pass++;
      n_checks++; if (bus.err_cnt !== 8'(m_err)) $display("FAIL chk_err_cnt: got %0d expected %0d", bus.err_cnt, m_err); else n_pass++;
      n_checks++; if (mon_valid - v0 != 0) $display("FAIL chk_no_cmd: got %0d valid cycles expected 0", mon_valid - v0); else n_pass++;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_junk_hold;
      int e0;
      logic [31:0] e, o;
      logic [7:0] op, ad, dh, dl;
      e0 = mon_chk + mon_tmo + mon_ovr;
      op = 8'h02; ad = 8'h20; dh = 8'h12; dl = 8'h34;
      send_byte(8'h00, 2, 1);
      send_byte(8'hFF, 2, 1);
      send_byte(8'h12, 2, 1);
      send_frame(op, ad, dh, dl, op ^ ad ^ dh ^ dl, 2, 1);
      settle(4);
      n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL junk_cmd_count: got %0d expected 1", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++; if (o !== e) $display("FAIL junk_cmd: got %h expected %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
      n_checks++; if (mon_chk + mon_tmo + mon_ovr - e0 != 0) $display("FAIL junk_errors: got %0d expected 0", mon_chk + mon_tmo + mon_ovr - e0); else n_pass++;
   endtask

   task automatic test_timeout;
      int hits, first;
      logic [31:0] e, o;
      hits = 0; first = -1;
      send_byte(8'h55, 1, 1);
      @(negedge clk);
      bus.rx_data  = 8'h01;
      bus.rx_valid = 1'b1;
      model_feed(8'h01);
      for (int i = 1; i <= T + 10; i++) begin
         @(negedge clk);
         if (i == 1) bus.rx_valid = 1'b0;
         #2;
         if (bus.err_timeout) begin
            hits++;
            if (first < 0) first = i;
         end
      end
      m_n = 0;
      m_err++;
      n_checks++; if (hits != 1) $display("FAIL timeout_pulses: got %0d expected 1", hits); else n_pass++;
      n_checks++; if (first != T + 1) $display("FAIL timeout_cycle: got %0d expected %0d", first, T + 1); else n_pass++;
      n_checks++; if (bus.err_cnt !== 8'(m_err)) $display("FAIL timeout_err_cnt: got %0d expected %0d", bus.err_cnt, m_err); else n_pass++;
      send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h0D, 1, 2);
      settle(4);
      n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL timeout_next_count: got %0d expected 1", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++; if (o !== e) $display("FAIL timeout_next_cmd: got %h expected %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_overrun;
      int o0;
      logic [31:0] e, o;
      o0 = mon_ovr;
      bus.cmd_ready = 1'b0;
      send_frame(8'h01, 8'h10, 8'hAB, 8'hCD, 8'h77, 1, 1);
      send_frame(8'h02, 8'h10, 8'hAB, 8'hCD, 8'h74, 1, 1);
      settle(3);
      void'(exp_q.pop_back());
      m_err++;
      n_checks++; if (bus.cmd_valid !== 1'b1) $display("FAIL overrun_valid_held: got %b expected 1", bus.cmd_valid); else n_pass++;
      n_checks++; if (bus.cmd_op !== 8'h01) $display("FAIL overrun_op_kept: got %h expected 01", bus.cmd_op); else n_pass++;
      n_checks++; if (mon_ovr - o0 != 1) $display("FAIL overrun_pulses: got %0d expected 1", mon_ovr - o0); else n_pass++;
      n_checks++; if (bus.err_cnt !== 8'(m_err)) $display("FAIL overrun_err_cnt: got %0d expected %0d", bus.err_cnt, m_err); else n_pass++;
      @(negedge clk);
      bus.cmd_ready = 1'b1;
      settle(1);
      n_checks++; if (bus.cmd_valid !== 1'b0) $display("FAIL overrun_valid_drop: got %b expected 0", bus.cmd_valid); else n_pass++;
      n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL overrun_cmd_count: got %0d expected 1", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++; if (o !== e) $display("FAIL overrun_cmd: got %h expected %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back;
      logic [7:0] op, ad, dh, dl;
      logic [31:0] e, o;
      bus.cmd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         op = 8'($urandom); ad = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
         send_frame(op, ad, dh, dl, op ^ ad ^ dh ^ dl, 1, 0);
      end
      settle(4);
      n_checks++; if (obs_q.size() != exp_q.size() || exp_q.size() != 3) $display("FAIL b2b_cmd_count: got %0d expected 3", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++; if (o !== e) $display("FAIL b2b_cmd: got %h expected %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid;
      logic [31:0] e, o;
      bus.cmd_ready = 1'b0;
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1, 1);
      send_byte(8'h55, 1, 1);
      send_byte(8'h01, 1, 1);
      send_byte(8'h10, 1, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      n_checks++; if (bus.cmd_valid !== 1'b0) $display("FAIL rstmid_cmd_valid: got %b expected 0", bus.cmd_valid); else n_pass++;
      n_checks++; if (bus.cmd_op !== 8'h00) $display("FAIL rstmid_cmd_op: got %h expected 00", bus.cmd_op); else n_pass++;
      n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL rstmid_err_cnt: got %0d expected 0", bus.err_cnt); else n_pass++;
      m_n = 0; m_err = 0;
      exp_q.delete(); obs_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.cmd_ready = 1'b1;
      send_frame(8'h01, 8'h10, 8'hAB, 8'hCD, 8'h77, 1, 1);
      settle(4);
      n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL rstmid_cmd_count: got %0d expected 1", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++; if (o !== e) $display("FAIL rstmid_cmd: got %h expected %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random;
      int c0, m0, sel;
      logic [7:0] op, ad, dh, dl, ck;
      logic [31:0] e, o;
      c0 = mon_chk; m0 = m_err;
      bus.cmd_ready = 1'b1;
      repeat (30) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(0, 3));
         end else begin
            op = 8'($urandom); ad = 8'($urandom); dh = 8'($urandom); dl = 8'($urandom);
            ck = op ^ ad ^ dh ^ dl;
            if (sel == 3) ck = ck ^ 8'($urandom_range(1, 255));
            send_frame(op, ad, dh, dl, ck, $urandom_range(1, 3), $urandom_range(0, 3));
         end
      end
      settle(4);
      n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_cmd_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++; if (o !== e) $display("FAIL rand_cmd: got %h expected %h", o, e); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
      n_checks++; if (mon_chk - c0 != m_err - m0) $display("FAIL rand_chk_pulses: got %0d expected %0d", mon_chk - c0, m_err - m0); else n_pass++;
      n_checks++; if (bus.err_cnt !== 8'(m_err)) $display("FAIL rand_err_cnt: got %0d expected %0d", bus.err_cnt, m_err); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_chk_error();
      test_junk_hold();
      test_timeout();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
